// File: rtl/d_ff_async_rstn.sv
// Parameterised D flip-flop with asynchronous active-high reset.
// q_not is the combinational complement of q and holds no state of its own.
module d_ff_async_rstn #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_not
);

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

    assign q_not = ~q;

endmodule

// File: tb/tb_d_ff_async_rstn.sv
// Scoreboard bench for d_ff_async_rstn: a 1-bit default instance and an
// 8-bit instance with RESET_VALUE 8'hA5 share clock and reset.
`timescale 1ns/1ps
module tb_d_ff_async_rstn;

    logic       clk;
    logic       reset;
    logic       d1;
    logic       q1;
    logic       qn1;
    logic [7:0] d8;
    logic [7:0] q8;
    logic [7:0] qn8;

    int vectors;
    int miscompares;

    typedef struct {
        string      name;
        bit         wide;
        logic [7:0] q;
        logic [7:0] qn;
    } exp_t;

    exp_t sb[$];
    logic captured;

    d_ff_async_rstn u_dut1 (
        .clk   (clk),
        .reset (reset),
        .d     (d1),
        .q     (q1),
        .q_not (qn1)
    );

    d_ff_async_rstn #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .d     (d8),
        .q     (q8),
        .q_not (qn8)
    );

    initial begin
        clk = 1'b0;
        forever #500 clk = ~clk;
    end

    task automatic push_exp(input string name, input bit wide,
                            input logic [7:0] q, input logic [7:0] qn);
        exp_t e;
        e.name = name;
        e.wide = wide;
        e.q    = q;
        e.qn   = qn;
        sb.push_back(e);
    endtask

    task automatic push_narrow(input string name, input logic q);
        push_exp(name, 1'b0, {7'd0, q}, {7'd0, ~q});
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s at %0t: got q/q_not=%h required %h", name, $time, act, exp_v);
        end
    endtask

    // Monitor: pops each expectation as soon as it is posted and compares it
    // against whichever instance it targets.
    initial begin
        exp_t e;
        forever begin
            wait (sb.size() > 0);
            e = sb.pop_front();
            if (e.wide) check(e.name, {q8, qn8}, {e.q, e.qn});
            else        check(e.name, {7'd0, q1, 7'd0, qn1}, {e.q, e.qn});
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        d1          = 1'b0;
        d8          = 8'h3C;
        #1;
        push_narrow("reset_t0_w1", 1'b0);
        push_exp("reset_t0_w8", 1'b1, 8'hA5, 8'h5A);

        // d toggles while reset is held: outputs must stay at reset value
        for (int i = 0; i < 4; i++) begin
            #($urandom_range(1000, 3000));
            d1 = ~d1;
            #1;
            push_narrow("reset_hold_w1", 1'b0);
            push_exp("reset_hold_w8", 1'b1, 8'hA5, 8'h5A);
        end

        // release mid-cycle: outputs keep reset value until the next edge
        @(negedge clk);
        d1    = 1'b1;
        reset = 1'b0;
        #1;
        push_narrow("release_hold_w1", 1'b0);
        push_exp("release_hold_w8", 1'b1, 8'hA5, 8'h5A);
        @(posedge clk);
        captured = d1;
        #1;
        push_narrow("first_capture_w1", captured);
        push_exp("first_capture_w8", 1'b1, 8'h3C, 8'hC3);

        // normal operation: d changes (with glitches) between edges
        for (int i = 0; i < 8; i++) begin
            int k;
            k = $urandom_range(1, 3);
            for (int j = 1; j < k; j++) begin
                @(posedge clk);
                #1;
                push_narrow("idle_edge", captured);
            end
            @(negedge clk);
            #($urandom_range(50, 400));
            d1 = ~d1;
            #20 d1 = ~d1;
            #20 d1 = ~d1;
            #1;
            push_narrow("hold_between_edges", captured);
            @(posedge clk);
            captured = d1;
            #1;
            push_narrow("capture_at_edge", captured);
        end

        // capture 1, change d, then assert reset mid-cycle
        @(negedge clk);
        d1 = 1'b1;
        @(posedge clk);
        #1;
        push_narrow("capture_one", 1'b1);
        #99 d1 = 1'b0;
        #99 reset = 1'b1;
        #1;
        push_narrow("async_assert_w1", 1'b0);
        push_exp("async_assert_w8", 1'b1, 8'hA5, 8'h5A);

        // reset held across an edge with d = 1 wins
        d1 = 1'b1;
        @(posedge clk);
        #1;
        push_narrow("reset_wins_edge_w1", 1'b0);
        push_exp("reset_wins_edge_w8", 1'b1, 8'hA5, 8'h5A);

        // drop reset mid-cycle with d = 1
        @(negedge clk);
        reset = 1'b0;
        #1;
        push_narrow("drop_reset_hold", 1'b0);
        @(posedge clk);
        #1;
        push_narrow("drop_reset_capture_w1", 1'b1);
        push_exp("drop_reset_capture_w8", 1'b1, 8'h3C, 8'hC3);

        fork
            wait (sb.size() == 0);
            #10000;
        join_any
        disable fork;
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending entries required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
